// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the EX-stage operand forwarding and load-use hazard control.
// Holds mux select encodings and the per-stage destination record.
package fwd_hazard_ctrl_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             regwrite;
      logic             memread;
   } stage_rec_t;

   // A stage can supply a forwarded value only if it really writes a non-$0 register.
   function automatic logic is_writer(input stage_rec_t r);
      return r.valid && r.regwrite && (r.dest != '0);
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_select.sv
// Per-operand forward select: youngest producer (EX) beats MEM, otherwise
// the register file supplies the operand.
import fwd_hazard_ctrl_pkg::*;

module fwd_select #(
   parameter int W = REG_W
) (
   input  logic         uses,
   input  logic [W-1:0] src,
   input  logic         ex_wr,
   input  logic [W-1:0] ex_dest,
   input  logic         mem_wr,
   input  logic [W-1:0] mem_dest,
   output logic [1:0]   sel
);

   always_comb begin
      sel = FWD_REGFILE;
      if (uses && ex_wr && (ex_dest == src))
         sel = FWD_EXMEM;
      else if (uses && mem_wr && (mem_dest == src))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage pipeline: tracks
// EX/MEM/WB destination records, registers forward selects, stalls on load-use.
import fwd_hazard_ctrl_pkg::*;

module fwd_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  flush,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall,
   output logic                  bubble,
   output logic [CNT_W-1:0]      stall_count
);

   stage_rec_t ex_rec, mem_rec, wb_rec, ex_nxt;
   logic       hazard;
   logic       ex_wr, mem_wr;
   logic [1:0] sel_a_nxt, sel_b_nxt;
   logic       unused_rec;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign ex_wr  = is_writer(ex_rec);
   assign mem_wr = is_writer(mem_rec);

   // WB is tracked for pipeline visibility only; no forwarding path reads it.
   assign unused_rec = ^{wb_rec, mem_rec.memread};

   always_comb begin
      hazard = id_valid && ex_rec.valid && ex_rec.memread && (ex_rec.dest != '0) &&
               ((id_uses_rs && (id_rs == ex_rec.dest)) ||
                (id_uses_rt && (id_rt == ex_rec.dest)));
      stall  = hazard && !flush;
      bubble = stall || flush || !id_valid;
   end

   always_comb begin
      ex_nxt          = '0;
      ex_nxt.valid    = !bubble;
      ex_nxt.dest     = id_dest;
      ex_nxt.regwrite = id_regwrite;
      ex_nxt.memread  = id_memread;
   end

   fwd_select #(.W(REG_ADDR_W)) u_sel_a (
      .uses     (id_uses_rs),
      .src      (id_rs),
      .ex_wr    (ex_wr),
      .ex_dest  (ex_rec.dest),
      .mem_wr   (mem_wr),
      .mem_dest (mem_rec.dest),
      .sel      (sel_a_nxt)
   );

   fwd_select #(.W(REG_ADDR_W)) u_sel_b (
      .uses     (id_uses_rt),
      .src      (id_rt),
      .ex_wr    (ex_wr),
      .ex_dest  (ex_rec.dest),
      .mem_wr   (mem_wr),
      .mem_dest (mem_rec.dest),
      .sel      (sel_b_nxt)
   );

   // ID -> EX -> MEM -> WB; MEM and WB keep advancing while ID is stalled.
   always_ff @(posedge clk) begin
      ex_rec    <= ex_nxt;
      mem_rec   <= ex_rec;
      wb_rec    <= mem_rec;
      fwd_a_sel <= bubble ? FWD_REGFILE : sel_a_nxt;
      fwd_b_sel <= bubble ? FWD_REGFILE : sel_b_nxt;
      if (stall)
         stall_count <= sat_inc(stall_count);
      if (rst) begin
         ex_rec.valid  <= 1'b0;
         mem_rec.valid <= 1'b0;
         wb_rec.valid  <= 1'b0;
         fwd_a_sel     <= FWD_REGFILE;
         fwd_b_sel     <= FWD_REGFILE;
         stall_count   <= '0;
      end
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequences the two 32-bit 3:1 ALU-operand forwarding muxes in the 5-stage MIPS pipeline.
- Tracks destination-register state for the EX, MEM and WB stages internally.
- Produces registered 2-bit forward selects for the instruction entering EX.
- Detects load-use hazards, issues a one-cycle stall with bubble insertion, and counts stall cycles.

Parameters:
REG_ADDR_W, 5, register-specifier width
CNT_W, 16, stall-counter width

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_ADDR_W  ID source register A
id_rt  in  REG_ADDR_W  ID source register B
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  REG_ADDR_W  ID destination register
id_regwrite  in  1  ID instruction writes register file
id_memread  in  1  ID instruction is a load
flush  in  1  branch taken; kill ID instruction this cycle
fwd_a_sel  out  2  mux select for ALU operand A (EX stage)
fwd_b_sel  out  2  mux select for ALU operand B (EX stage)
stall  out  1  hold PC and IF/ID this cycle
bubble  out  1  EX receives a NOP next cycle
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; all state changes occur on the rising edge of clk.
- Select encoding matches the mux:
  - 00 = register file
  - 01 = EX/MEM result
  - 10 = MEM/WB result
  - 11 is never driven.
- Internal stage records for EX, MEM and WB each hold: valid, dest, regwrite, memread.
- Every cycle the records advance: EX <= ID (or bubble), MEM <= EX, WB <= MEM. MEM and WB advance even during a stall.
- A stage is a "writer" when valid && regwrite && dest != 0. Register $0 is never forwarded.
- Forward select per operand X in {rs, rt}, computed from the ID fields and registered into EX (one-cycle latency, visible while that instruction is in EX):
  - 01 if id_uses_X && current-EX is a writer && EX.dest == id_X
  - else 10 if id_uses_X && current-MEM is a writer && MEM.dest == id_X
  - else 00
  - EX/MEM has priority over MEM/WB (youngest producer wins).
- Load-use hazard (combinational, same cycle): id_valid && EX.valid && EX.memread && EX.dest != 0 && ((id_uses_rs && id_rs == EX.dest) || (id_uses_rt && id_rt == EX.dest)).
- stall = hazard && !flush.
- bubble = stall || flush || !id_valid. On bubble, the EX record loads valid=0 and selects load 00.
- The stall lasts exactly one cycle. Next cycle the load is in MEM and the same ID instruction receives select 01 or 10 by the normal rules: MEM-stage load data is forwarded as 10 after one more cycle, so the selects are re-evaluated against the advanced records.
- flush and hazard in the same cycle: flush wins; no stall, ID instruction killed, stall_count unchanged.
- stall_count increments by 1 on each cycle stall=1 and saturates at all-ones.
- Reset values:
  - all stage valid bits 0
  - fwd_a_sel = fwd_b_sel = 00
  - stall_count = 0
  - stall and bubble then follow from the cleared state: stall=0, and bubble=!id_valid.
- Reset asserted mid-stall clears all records; the following cycle the ID instruction sees no hazard.

Decomposition:
- Shared package: FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10; stage-record struct (valid, dest, regwrite, memread).
- Sub-module fwd_select: per-operand comparator returning the 2-bit select, instantiated twice (rs, rt).

Test Plan:
- Back-to-back ALU ops: add $3 followed by sub using rs=$3 -> fwd_a_sel=01 on the cycle sub is in EX; fwd_b_sel=00.
- Gap of one: add $5, nop, or using rt=$5 -> fwd_b_sel=10. The same with both EX and MEM writing $5 -> fwd_b_sel=01.
- Load-use: lw $7 then add rs=$7 -> stall=1 and bubble=1 for exactly one cycle; stall_count=1; add then enters EX with fwd_a_sel=10.
- $0 destination: ori $0 then add rs=$0 -> selects 00; lw $0 then a use of $0 -> no stall.
- Flush during hazard: lw $4, a use of $4, and flush=1 in the same cycle -> stall=0, bubble=1, stall_count unchanged.
- Reset mid-stall: rst=1 while stall=1 -> next cycle selects=00, stall=0, stall_count=0. Force 2^16 stalls -> stall_count holds at 16'hFFFF.
